// File: rtl/dc_fifo_l2_master.sv
// TCDM master stage of the dual-clock FIFO path: turns single-cycle request pulses into
// TCDM transfers and guarantees exactly one response pulse per accepted request.
module dc_fifo_l2_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_req_i,
  input  logic        s_wen_i,
  input  logic [31:0] s_add_i,
  input  logic [31:0] s_wdata_i,
  input  logic [3:0]  s_be_i,
  output logic        s_r_valid_o,
  output logic [31:0] s_r_rdata_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic        m_wen_o,
  output logic [31:0] m_add_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_be_o,
  input  logic        m_r_valid_i,
  input  logic [31:0] m_r_rdata_i,
  input  logic        err_clr_i,
  output logic        err_timeout_o,
  output logic        err_overrun_o,
  output logic        busy_o
);

  localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, RESP, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stale_q, stale_d;
  logic          pend_q, pend_d;
  logic          accept;
  logic          load_rdata;
  logic [31:0]   rdata_d;
  logic          set_timeout, set_overrun;
  logic          cnt_max;
  logic          busy;

  assign cnt_max     = (cnt_q == CNT_MAX);
  assign busy        = (state_q == ISSUE) || (state_q == WAIT_R) || (state_q == DRAIN);
  assign busy_o      = busy;
  assign m_req_o     = (state_q == ISSUE);
  assign s_r_valid_o = (state_q == RESP);

  always_comb begin
    state_d     = state_q;
    stale_d     = stale_q;
    pend_d      = pend_q;
    accept      = 1'b0;
    load_rdata  = 1'b0;
    rdata_d     = m_r_rdata_i;
    set_timeout = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_req_i) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        set_overrun = s_req_i;
        if (m_gnt_i) begin
          state_d = WAIT_R;
        end else if (cnt_max) begin
          state_d     = RESP;
          load_rdata  = 1'b1;
          rdata_d     = ERR_RDATA;
          set_timeout = 1'b1;
        end
      end
      WAIT_R: begin
        set_overrun = s_req_i;
        if (m_r_valid_i) begin
          state_d    = RESP;
          load_rdata = 1'b1;
        end else if (cnt_max) begin
          // The interconnect still owes us a response; remember to swallow it.
          state_d     = RESP;
          load_rdata  = 1'b1;
          rdata_d     = ERR_RDATA;
          set_timeout = 1'b1;
          stale_d     = 1'b1;
        end
      end
      RESP: begin
        accept = s_req_i;
        if (stale_q) begin
          state_d = DRAIN;
          pend_d  = pend_q | s_req_i;
        end else if (s_req_i) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        accept = s_req_i;
        if (m_r_valid_i || cnt_max) begin
          // A request arriving on the exit cycle is issued like a pending one.
          set_timeout = !m_r_valid_i;
          stale_d     = 1'b0;
          pend_d      = 1'b0;
          state_d     = (pend_q || s_req_i) ? ISSUE : IDLE;
        end else begin
          pend_d = pend_q | s_req_i;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (busy)          cnt_d = cnt_q + 1'b1;
    else                    cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stale_q       <= 1'b0;
      pend_q        <= 1'b0;
      m_wen_o       <= 1'b0;
      m_add_o       <= '0;
      m_wdata_o     <= '0;
      m_be_o        <= '0;
      s_r_rdata_o   <= '0;
      err_timeout_o <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stale_q       <= stale_d;
      pend_q        <= pend_d;
      err_timeout_o <= set_timeout | (err_timeout_o & ~err_clr_i);
      err_overrun_o <= set_overrun | (err_overrun_o & ~err_clr_i);
      if (accept) begin
        m_wen_o   <= s_wen_i;
        m_add_o   <= s_add_i;
        m_wdata_o <= s_wdata_i;
        m_be_o    <= s_be_i;
      end
      if (load_rdata) s_r_rdata_o <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dc_fifo_l2_master.sv
// Bench for dc_fifo_l2_master: directed vector table, multi-cycle corner sequences and
// randomized transfers checked against a transaction-level expectation.
module tb_dc_fifo_l2_master;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_req_i = 1'b0, s_wen_i = 1'b0;
  logic [31:0] s_add_i = '0, s_wdata_i = '0;
  logic [3:0]  s_be_i = '0;
  logic        s_r_valid_o;
  logic [31:0] s_r_rdata_o;
  logic        m_req_o, m_gnt_i = 1'b0, m_wen_o;
  logic [31:0] m_add_o, m_wdata_o;
  logic [3:0]  m_be_o;
  logic        m_r_valid_i = 1'b0;
  logic [31:0] m_r_rdata_i = '0;
  logic        err_clr_i = 1'b0, err_timeout_o, err_overrun_o, busy_o;

  int checks = 0;
  int failures = 0;

  dc_fifo_l2_master #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_i(s_req_i), .s_wen_i(s_wen_i), .s_add_i(s_add_i), .s_wdata_i(s_wdata_i),
    .s_be_i(s_be_i), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_wen_o(m_wen_o), .m_add_o(m_add_o),
    .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_r_valid_i(m_r_valid_i),
    .m_r_rdata_i(m_r_rdata_i), .err_clr_i(err_clr_i), .err_timeout_o(err_timeout_o),
    .err_overrun_o(err_overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    int          exp_req;
    logic [31:0] exp_data;
    logic        exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock; all inputs are pulses, so they drop after every edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    s_req_i = 1'b0; m_gnt_i = 1'b0; m_r_valid_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                           input logic [3:0] be);
    s_req_i = 1'b1; s_wen_i = wen; s_add_i = add; s_wdata_i = wdata; s_be_i = be;
  endtask

  // Issues a request in the current cycle and plays the interconnect; returns in the RESP cycle.
  // gnt_dly >= T means the grant never comes.
  task automatic xfer(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                      input logic [3:0] be, input int gnt_dly, input int rv_dly,
                      input logic [31:0] rdata, input int exp_req, input logic [31:0] exp_data,
                      input bit ovr, input bit spur);
    int bad = 0;
    int quiet = 0;
    int req_cycles = 0;
    drive_req(wen, add, wdata, be);
    step();
    for (int k = 0; k < 2 * T && m_req_o; k++) begin
      req_cycles++;
      if ({m_wen_o, m_add_o, m_wdata_o, m_be_o} !== {wen, add, wdata, be}) bad++;
      m_gnt_i = (k == gnt_dly);
      if (spur) begin
        m_r_valid_i = 1'b1;
        m_r_rdata_i = ~rdata;
      end
      if (ovr && k == 0) drive_req(~wen, ~add, $urandom(), ~be);
      step();
    end
    chk("payload_stable", 32'(bad), 32'd0);
    chk("req_cycles", 32'(req_cycles), 32'(exp_req));
    if (gnt_dly < T) begin
      for (int k = 0; k < rv_dly; k++) begin
        if (s_r_valid_o || m_req_o) quiet++;
        step();
      end
      m_r_valid_i = 1'b1;
      m_r_rdata_i = rdata;
      step();
    end
    chk("wait_quiet", 32'(quiet), 32'd0);
    chk1("resp_pulse", s_r_valid_o, 1'b1);
    chk("resp_data", s_r_rdata_o, exp_data);
  endtask

  initial begin
    bit exp_ovr;
    int bad;

    vecs[0] = '{1'b1, 32'h1C010000, 32'h0,        4'hF, 0, 0, 32'h12345678, 1, 32'h12345678, 1'b0};
    vecs[1] = '{1'b0, 32'h1C010040, 32'hCAFEF00D, 4'h3, 5, 2, 32'h0000BEEF, 6, 32'h0000BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h1C010080, 32'h0,        4'hF, 99, 0, 32'h0,       8, ERR,          1'b1};
    vecs[3] = '{1'b1, 32'h1C0100C0, 32'h0,        4'hF, 7, 1, 32'h5A5A0001, 8, 32'h5A5A0001, 1'b0};
    vecs[4] = '{1'b0, 32'h1C010100, 32'h11112222, 4'hC, 2, 7, 32'h77770007, 3, 32'h77770007, 1'b0};
    vecs[5] = '{1'b1, 32'h1C010140, 32'h0,        4'h1, 3, 4, 32'h00000000, 4, 32'h00000000, 1'b0};

    repeat (3) step();
    chk1("rst_m_req", m_req_o, 1'b0);
    chk1("rst_s_r_valid", s_r_valid_o, 1'b0);
    chk("rst_s_r_rdata", s_r_rdata_o, 32'h0);
    chk("rst_m_add", m_add_o, 32'h0);
    chk("rst_m_wdata", m_wdata_o, 32'h0);
    chk("rst_m_be", {28'h0, m_be_o}, 32'h0);
    chk1("rst_m_wen", m_wen_o, 1'b0);
    chk1("rst_err_to", err_timeout_o, 1'b0);
    chk1("rst_err_ovr", err_overrun_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    #2 rst_ni = 1'b1;
    step();

    foreach (vecs[i]) begin
      step();
      xfer(vecs[i].wen, vecs[i].add, vecs[i].wdata, vecs[i].be, vecs[i].gnt_dly, vecs[i].rv_dly,
           vecs[i].rdata, vecs[i].exp_req, vecs[i].exp_data, 1'b0, 1'b0);
      chk1("vec_err_to", err_timeout_o, vecs[i].exp_to);
      step();
      chk1("vec_idle_no_pulse", s_r_valid_o, 1'b0);
      chk1("vec_idle_busy", busy_o, 1'b0);
      err_clr_i = 1'b1;
      step();
      chk1("vec_err_cleared", err_timeout_o, 1'b0);
    end

    // Response timeout, then a request parked in DRAIN behind the late response.
    drive_req(1'b1, 32'h1C020000, 32'h0, 4'hF);
    step();
    chk1("rto_issue", m_req_o, 1'b1);
    m_gnt_i = 1'b1;
    step();
    bad = 0;
    for (int k = 0; k < T; k++) begin
      if (s_r_valid_o || m_req_o) bad++;
      step();
    end
    chk("rto_wait_quiet", 32'(bad), 32'd0);
    chk1("rto_resp", s_r_valid_o, 1'b1);
    chk("rto_data", s_r_rdata_o, ERR);
    chk1("rto_err", err_timeout_o, 1'b1);
    step();
    chk1("drain_busy", busy_o, 1'b1);
    chk1("drain_no_pulse", s_r_valid_o, 1'b0);
    drive_req(1'b0, 32'h1C030000, 32'h0BADF00D, 4'h3);
    step();
    chk1("drain_no_issue", m_req_o, 1'b0);
    m_r_valid_i = 1'b1;
    m_r_rdata_i = 32'hAAAA5555;
    step();
    chk1("pend_issue", m_req_o, 1'b1);
    chk("pend_add", m_add_o, 32'h1C030000);
    chk("pend_wdata", m_wdata_o, 32'h0BADF00D);
    chk1("late_discarded_pulse", s_r_valid_o, 1'b0);
    chk("late_discarded_data", s_r_rdata_o, ERR);
    m_gnt_i = 1'b1;
    step();
    m_r_valid_i = 1'b1;
    m_r_rdata_i = 32'h01020304;
    step();
    chk1("pend_resp", s_r_valid_o, 1'b1);
    chk("pend_data", s_r_rdata_o, 32'h01020304);
    step();
    chk1("pend_single_pulse", s_r_valid_o, 1'b0);
    chk1("pend_idle", busy_o, 1'b0);
    err_clr_i = 1'b1;
    step();

    // Overrun while waiting for the response.
    drive_req(1'b1, 32'h1C040000, 32'h0, 4'hF);
    step();
    m_gnt_i = 1'b1;
    step();
    chk1("ovr_before", err_overrun_o, 1'b0);
    drive_req(1'b0, 32'h1C050000, 32'hFFFFFFFF, 4'h0);
    step();
    chk1("ovr_set", err_overrun_o, 1'b1);
    chk("ovr_payload_kept", m_add_o, 32'h1C040000);
    m_r_valid_i = 1'b1;
    m_r_rdata_i = 32'h13579BDF;
    step();
    chk1("ovr_resp", s_r_valid_o, 1'b1);
    chk("ovr_data", s_r_rdata_o, 32'h13579BDF);
    chk1("ovr_sticky", err_overrun_o, 1'b1);
    err_clr_i = 1'b1;
    step();
    chk1("ovr_cleared", err_overrun_o, 1'b0);
    chk1("ovr_ignored_idle", busy_o, 1'b0);

    // Back-to-back: each request issued in the previous RESP cycle.
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'h1C060000 + 32'(i * 4), 32'h0, 4'hF, 0, 0, 32'hB2B00000 + 32'(i), 1,
           32'hB2B00000 + 32'(i), 1'b0, 1'b0);
    step();
    chk1("b2b_idle", busy_o, 1'b0);

    // Randomized transfers with overruns, spurious responses, error clears and gaps.
    exp_ovr = 1'b0;
    err_clr_i = 1'b1;
    step();
    for (int i = 0; i < 150; i++) begin
      logic [31:0] rd;
      int gd, rv;
      bit ovr;
      if ($urandom_range(0, 1) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          if ($urandom_range(0, 3) == 0) begin
            m_r_valid_i = 1'b1;
            m_r_rdata_i = $urandom();
          end
          step();
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        err_clr_i = 1'b1;
        exp_ovr = 1'b0;
      end
      gd = int'($urandom_range(0, T - 1));
      rv = int'($urandom_range(0, T - 1));
      rd = $urandom();
      ovr = ($urandom_range(0, 3) == 0);
      xfer(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)), gd, rv,
           rd, gd + 1, rd, ovr, ($urandom_range(0, 4) == 0));
      exp_ovr = exp_ovr | ovr;
      chk1("rand_err_ovr", err_overrun_o, exp_ovr);
      chk1("rand_err_to", err_timeout_o, 1'b0);
    end
    xfer(1'b1, 32'h1C070000, 32'h0, 4'hF, 1, 1, 32'h600DD00D, 2, 32'h600DD00D, 1'b0, 1'b0);
    step();

    // Asynchronous reset while a grant is outstanding.
    drive_req(1'b1, 32'h1C0F0000, 32'h0, 4'hF);
    step();
    drive_req(1'b0, 32'h1C0F0004, 32'h0, 4'h0);
    step();
    chk1("mid_req_high", m_req_o, 1'b1);
    chk1("mid_ovr_set", err_overrun_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk1("arst_m_req", m_req_o, 1'b0);
    chk1("arst_busy", busy_o, 1'b0);
    chk1("arst_ovr", err_overrun_o, 1'b0);
    chk("arst_m_add", m_add_o, 32'h0);
    chk("arst_rdata", s_r_rdata_o, 32'h0);
    #3 rst_ni = 1'b1;
    step();
    chk1("post_rst_idle", busy_o, 1'b0);
    chk1("post_rst_no_req", m_req_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
